prefetch_buffer: RTL and testbench
==================================

# prefetch_buffer

Parametrised instruction prefetch buffer between the fetch-address generator and the IF stage. It streams word-aligned fetches from the instruction cache into a DEPTH-entry circular word FIFO and presents one instruction per handshake at any halfword-aligned PC. It detects compressed (16-bit) instructions and reassembles 32-bit instructions that straddle two words. A flush discards all buffered and in-flight data and restarts fetching at a new PC, including dropping a response that arrives after the flush.

## Interface
- XLEN, 32, address/data width; only 32 is supported.
- DEPTH, 4, FIFO depth in words; power of two, ≥2.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard buffer and in-flight fetch; restart at flush_pc_i.
- flush_pc_i  in  XLEN  restart PC; bit 0 ignored (treated as 0).
- req_o  out  1  fetch request to the icache; held until ack_i.
- addr_o  out  XLEN  word-aligned fetch address; addr_o[1:0]=0, stable while req_o is held.
- ack_i  in  1  response valid; may coincide with the first cycle of req_o.
- rdata_i  in  XLEN  fetched word, valid with ack_i.
- valid_o  out  1  instr_o/pc_o/compressed_o are valid.
- ready_i  in  1  IF stage accepts the instruction when valid_o&ready_i.
- instr_o  out  32  instruction; upper 16 bits are 0 when compressed_o=1.
- pc_o  out  XLEN  PC of instr_o.
- compressed_o  out  1  instr_o[1:0]!=2'b11.

## Operation
- **State.**
  - FIFO: words, rd_ptr, wr_ptr, count (0..DEPTH).
  - cur_pc: PC of the head instruction.
  - fetch_addr: next word to request.
  - req_addr_q: latched outstanding address.
  - FSM: IDLE, WAIT, DROP.
- **Reset.** count=0, cur_pc=0, fetch_addr=0, FSM=IDLE. Resulting outputs: valid_o=0, req_o=1 (addr 0), pc_o=0.
- **Request FSM.** At most one request is outstanding.
  - IDLE: req_o = (count<DEPTH)&~flush_i; addr_o=fetch_addr.
    - req&ack: push, fetch_addr+=4, stay IDLE.
    - req&~ack: req_addr_q←fetch_addr, go to WAIT.
  - WAIT: req_o=1; addr_o=req_addr_q.
    - ack&~flush_i: push, fetch_addr+=4, go to IDLE.
    - ack&flush_i: discard, go to IDLE.
    - ~ack&flush_i: go to DROP.
  - DROP: req_o=1; addr_o=req_addr_q. On ack: discard, go to IDLE.
  - No overflow is possible. Issue requires count<DEPTH, and count never rises without an ack.
- **Extraction.** Let H = FIFO head word, N = next word.
  - cur_pc[1]=0:
    - If H[1:0]!=2'b11: compressed, instr={16'b0,H[15:0]}.
    - Else: instr=H. valid_o = count≥1.
  - cur_pc[1]=1, lo=H[31:16]:
    - If lo[1:0]!=2'b11: compressed, valid_o = count≥1.
    - Else: instr={N[15:0],lo}, valid_o = count≥2.
- **Consume** (valid_o&ready_i&~flush_i):
  - cur_pc += compressed ? 2 : 4.
  - Pop the head iff cur_pc[1] | ~compressed_o. At most one pop per cycle.
- **Simultaneous events.**
  - Push and pop in one cycle: count unchanged.
  - Pointers wrap modulo DEPTH.
  - fetch_addr and cur_pc wrap modulo 2^XLEN.
- **Flush priority.** flush_i overrides consume and push. Next cycle:
  - count=0, rd_ptr=wr_ptr.
  - cur_pc = {flush_pc_i[XLEN-1:1],1'b0}.
  - fetch_addr = {flush_pc_i[XLEN-1:2],2'b00}.
  - valid_o=0.
- **rst** overrides flush_i and everything else. In-flight acks after reset are not tracked: the icache is reset by the same rst.

## Timing
- valid_o, instr_o, pc_o and compressed_o are combinational from FIFO/cur_pc state. They do not depend on ready_i or ack_i in the same cycle.
- req_o/addr_o depend combinationally on flush_i and count only. They have no path from ack_i.
- Zero-wait icache (ack_i in the same cycle as req_o): one word per cycle sustained. A full-throughput aligned 32-bit stream gives valid_o every cycle once count≥1.
- Flush at cycle n, no outstanding request, zero-wait cache:
  - n+1: req_o=1 with the flush word.
  - n+2: valid_o=1 if aligned or compressed.
  - n+3: valid_o=1 if the target is a straddling 32-bit instruction.
- Flush during WAIT: the late response is dropped. The first new request is issued in the cycle after that ack.

## Test plan
- **Reset.** Hold rst 2 cycles; release; ack_i zero-wait with rdata = address. Expected:
  - req_o=1 with addr 0,4,8,12 on consecutive cycles.
  - valid_o=0 in the first cycle after rst release.
  - Then pc_o 0,4,8 …, with ready_i=1.
- **Compressed mix.** Words 0x0001_0001, 0x0000_0013. Expected:
  - (pc 0, instr 0x0001, c=1), (pc 2, instr 0x0001, c=1), (pc 4, instr 0x13, c=0).
  - One pop per word.
- **Straddle.** Flush to 0x102; words @0x100=0x0003_AAAA, @0x104=0xBBBB_0000. Expected:
  - instr_o=0x0000_0003, pc_o=0x102, c=0.
  - valid_o not asserted until both words are buffered.
- **Full buffer.** DEPTH=4, ready_i=0. Expected:
  - Exactly 4 acks accepted; then req_o=0.
  - After one consume, req_o reasserts the next cycle with addr 0x10.
- **Flush with outstanding request.** ack_i delayed 3 cycles; flush_i to 0x200 in WAIT. Expected:
  - FSM enters DROP; the late word is not pushed; valid_o=0.
  - Next req_o has addr 0x200.
- **Flush priority.** flush_i together with consume and ack in the same cycle. Expected:
  - count=0 next cycle.
  - pc_o equals the flush target once valid.
  - No stale instruction is ever presented.

Source files
------------

// File: rtl/prefetch_buffer_if.sv
// rtl/prefetch_buffer_if.sv - fetch-side and issue-side signals of the prefetch buffer
interface prefetch_buffer_if #(
  parameter int XLEN = 32
);
  logic            flush_i;
  logic [XLEN-1:0] flush_pc_i;
  logic            req_o;
  logic [XLEN-1:0] addr_o;
  logic            ack_i;
  logic [XLEN-1:0] rdata_i;
  logic            valid_o;
  logic            ready_i;
  logic [31:0]     instr_o;
  logic [XLEN-1:0] pc_o;
  logic            compressed_o;

  modport master (
    input  flush_i, flush_pc_i, ack_i, rdata_i, ready_i,
    output req_o, addr_o, valid_o, instr_o, pc_o, compressed_o
  );

  modport slave (
    output flush_i, flush_pc_i, ack_i, rdata_i, ready_i,
    input  req_o, addr_o, valid_o, instr_o, pc_o, compressed_o
  );
endinterface

// File: rtl/prefetch_buffer.sv
// rtl/prefetch_buffer.sv - instruction prefetch buffer with compressed and straddle extraction
module prefetch_buffer #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  prefetch_buffer_if.master bus
);
  localparam int          PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   nxt_ptr;
  logic [PW:0]     count;
  logic [XLEN-1:0] cur_pc;
  logic [XLEN-1:0] fetch_addr;
  logic [XLEN-1:0] req_addr_q;
  logic [XLEN-1:0] head;
  logic [15:0]     lo;
  logic            compressed;
  logic            push;
  logic            pop;
  logic            consume;

  // Request side never looks at ack_i, so the icache may answer combinationally.
  assign bus.req_o  = (state == S_IDLE) ? ((count < FULL) && !bus.flush_i) : 1'b1;
  assign bus.addr_o = (state == S_IDLE) ? fetch_addr : req_addr_q;

  assign push = bus.req_o && bus.ack_i && !bus.flush_i && (state != S_DROP);

  assign nxt_ptr    = rd_ptr + PW'(1);
  assign head       = mem[rd_ptr];
  assign lo         = cur_pc[1] ? head[31:16] : head[15:0];
  assign compressed = (lo[1:0] != 2'b11);

  // A straddling 32-bit instruction needs its upper half from the following word.
  assign bus.valid_o      = (cur_pc[1] && !compressed) ? (count >= (PW+1)'(2)) : (count != '0);
  assign bus.compressed_o = compressed;
  assign bus.pc_o         = cur_pc;
  assign bus.instr_o      = compressed ? {16'h0000, lo} :
                            (cur_pc[1] ? {mem[nxt_ptr][15:0], lo} : head);

  assign consume = bus.valid_o && bus.ready_i && !bus.flush_i;
  assign pop     = consume && (cur_pc[1] || !compressed);

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= bus.rdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      cur_pc     <= '0;
      fetch_addr <= '0;
      req_addr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + PW'(1);
        fetch_addr <= fetch_addr + XLEN'(4);
      end
      if (pop) begin
        rd_ptr <= nxt_ptr;
      end
      if (consume) begin
        cur_pc <= cur_pc + (compressed ? XLEN'(2) : XLEN'(4));
      end
      count <= count + (PW+1)'(push) - (PW+1)'(pop);

      case (state)
        S_IDLE: begin
          if (bus.req_o && !bus.ack_i) begin
            req_addr_q <= fetch_addr;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (bus.ack_i) begin
            state <= S_IDLE;
          end else if (bus.flush_i) begin
            state <= S_DROP;
          end
        end
        S_DROP: begin
          if (bus.ack_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Flush wins over push and consume; any late response is dropped via S_DROP.
      if (bus.flush_i) begin
        count      <= '0;
        rd_ptr     <= wr_ptr;
        cur_pc     <= bus.flush_pc_i & ~XLEN'(1);
        fetch_addr <= bus.flush_pc_i & ~XLEN'(3);
      end
    end
  end
endmodule

// File: tb/tb_prefetch_buffer.sv
// tb/tb_prefetch_buffer.sv - directed self-checking bench for prefetch_buffer
module tb_prefetch_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prefetch_buffer_if #(.XLEN(32)) bus ();
  prefetch_buffer #(.XLEN(32), .DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int lat      = 0;
  int wait_cnt = 0;
  int ack_cnt  = 0;
  logic [31:0] img [logic [31:0]];

  // Unlisted addresses return addr|3, i.e. an aligned 32-bit instruction.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (img.exists(a)) return img[a];
    return a | 32'h3;
  endfunction

  // icache model: answers a held request after lat idle cycles (lat=0 is zero-wait)
  always @(negedge clk) begin
    bus.ack_i = 1'b0;
    if (rst) begin
      wait_cnt = 0;
      ack_cnt  = 0;
    end else if (bus.req_o) begin
      if (wait_cnt >= lat) begin
        bus.ack_i = 1'b1;
        wait_cnt  = 0;
        ack_cnt++;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    bus.rdata_i = word_at(bus.addr_o);
  end

  task automatic apply_reset;
    rst            = 1'b1;
    bus.flush_i    = 1'b0;
    bus.flush_pc_i = '0;
    bus.ready_i    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] pc_exp;
    img.delete();
    lat = 0;
    apply_reset();
    bus.ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL reset_req[%0d]: got %b expected 1", i, bus.req_o); end
      n_checks++;
      if (bus.addr_o !== 32'(4 * i)) begin n_fail++; $display("FAIL reset_addr[%0d]: got %h expected %h", i, bus.addr_o, 32'(4 * i)); end
      if (i == 0) begin
        n_checks++;
        if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid0: got %b expected 0", bus.valid_o); end
        n_checks++;
        if (bus.pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc0: got %h expected 0", bus.pc_o); end
      end else begin
        pc_exp = 32'(4 * (i - 1));
        n_checks++;
        if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 1", i, bus.valid_o); end
        n_checks++;
        if (bus.pc_o !== pc_exp) begin n_fail++; $display("FAIL reset_pc[%0d]: got %h expected %h", i, bus.pc_o, pc_exp); end
        n_checks++;
        if (bus.instr_o !== (pc_exp | 32'h3)) begin n_fail++; $display("FAIL reset_instr[%0d]: got %h expected %h", i, bus.instr_o, pc_exp | 32'h3); end
      end
    end
  endtask

  task automatic test_compressed;
    logic [31:0] exp_pc [4];
    logic [31:0] exp_in [4];
    logic        exp_c  [4];
    exp_pc = '{32'h0, 32'h2, 32'h4, 32'h8};
    exp_in = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0013, 32'h0000_000B};
    exp_c  = '{1'b1, 1'b1, 1'b0, 1'b0};
    img.delete();
    img[32'h0] = 32'h0001_0001;
    img[32'h4] = 32'h0000_0013;
    lat = 0;
    apply_reset();
    bus.ready_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.valid_o !== 1'b1) begin n_fail++; $display("FAIL cmp_valid[%0d]: got %b expected 1", i, bus.valid_o); end
      n_checks++;
      if (bus.pc_o !== exp_pc[i]) begin n_fail++; $display("FAIL cmp_pc[%0d]: got %h expected %h", i, bus.pc_o, exp_pc[i]); end
      n_checks++;
      if (bus.instr_o !== exp_in[i]) begin n_fail++; $display("FAIL cmp_instr[%0d]: got %h expected %h", i, bus.instr_o, exp_in[i]); end
      n_checks++;
      if (bus.compressed_o !== exp_c[i]) begin n_fail++; $display("FAIL cmp_c[%0d]: got %b expected %b", i, bus.compressed_o, exp_c[i]); end
    end
  endtask

  task automatic test_straddle;
    int first;
    img.delete();
    img[32'h100] = 32'h0003_AAAA;
    img[32'h104] = 32'hBBBB_0000;
    lat = 1;
    apply_reset();
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h102;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    first = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        first = c;
        break;
      end
    end
    n_checks++;
    if (first !== 5) begin n_fail++; $display("FAIL straddle_first_valid_cycle: got %0d expected 5", first); end
    n_checks++;
    if (bus.instr_o !== 32'h0000_0003) begin n_fail++; $display("FAIL straddle_instr: got %h expected 00000003", bus.instr_o); end
    n_checks++;
    if (bus.pc_o !== 32'h102) begin n_fail++; $display("FAIL straddle_pc: got %h expected 00000102", bus.pc_o); end
    n_checks++;
    if (bus.compressed_o !== 1'b0) begin n_fail++; $display("FAIL straddle_c: got %b expected 0", bus.compressed_o); end
  endtask

  task automatic test_full;
    img.delete();
    lat = 0;
    apply_reset();
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (bus.req_o !== 1'b0) begin n_fail++; $display("FAIL full_req: got %b expected 0", bus.req_o); end
    n_checks++;
    if (ack_cnt !== 4) begin n_fail++; $display("FAIL full_acks: got %0d expected 4", ack_cnt); end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.req_o !== 1'b0 || ack_cnt !== 4) begin n_fail++; $display("FAIL full_hold: req %b acks %0d expected req 0 acks 4", bus.req_o, ack_cnt); end
    @(posedge clk);
    #1 bus.ready_i = 1'b1;
    @(posedge clk);
    #1 bus.ready_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_o !== 1'b1) begin n_fail++; $display("FAIL full_rereq: got %b expected 1", bus.req_o); end
    n_checks++;
    if (bus.addr_o !== 32'h10) begin n_fail++; $display("FAIL full_readdr: got %h expected 00000010", bus.addr_o); end
    n_checks++;
    if (bus.pc_o !== 32'h4) begin n_fail++; $display("FAIL full_pc: got %h expected 00000004", bus.pc_o); end
  endtask

  task automatic test_flush_wait;
    bit seen;
    img.delete();
    lat = 3;
    apply_reset();
    repeat (2) @(posedge clk);
    #1;
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h200;
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_o !== 1'b1 || bus.addr_o !== 32'h0) begin n_fail++; $display("FAIL drop_hold: req %b addr %h expected req 1 addr 0", bus.req_o, bus.addr_o); end
    n_checks++;
    if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_valid: got %b expected 0", bus.valid_o); end
    @(negedge clk);
    n_checks++;
    if (bus.req_o !== 1'b1 || bus.addr_o !== 32'h200) begin n_fail++; $display("FAIL drop_newreq: req %b addr %h expected req 1 addr 200", bus.req_o, bus.addr_o); end
    n_checks++;
    if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL drop_nopush: got valid %b expected 0", bus.valid_o); end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL drop_timeout: valid %b expected 1", seen); end
    n_checks++;
    if (bus.pc_o !== 32'h200 || bus.instr_o !== 32'h203) begin n_fail++; $display("FAIL drop_first: pc %h instr %h expected pc 200 instr 203", bus.pc_o, bus.instr_o); end
  endtask

  task automatic test_flush_priority;
    bit seen;
    img.delete();
    lat = 1;
    apply_reset();
    repeat (3) @(posedge clk);
    #1;
    bus.ready_i    = 1'b1;
    bus.flush_i    = 1'b1;
    bus.flush_pc_i = 32'h301;
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b1 || bus.pc_o !== 32'h0) begin n_fail++; $display("FAIL prio_pre: valid %b pc %h expected valid 1 pc 0", bus.valid_o, bus.pc_o); end
    @(posedge clk);
    #1 bus.flush_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.valid_o !== 1'b0) begin n_fail++; $display("FAIL prio_empty: got valid %b expected 0", bus.valid_o); end
    n_checks++;
    if (bus.req_o !== 1'b1 || bus.addr_o !== 32'h300) begin n_fail++; $display("FAIL prio_req: req %b addr %h expected req 1 addr 300", bus.req_o, bus.addr_o); end
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++;
    if (seen !== 1'b1) begin n_fail++; $display("FAIL prio_timeout: valid %b expected 1", seen); end
    n_checks++;
    if (bus.pc_o !== 32'h300 || bus.instr_o !== 32'h303) begin n_fail++; $display("FAIL prio_first: pc %h instr %h expected pc 300 instr 303", bus.pc_o, bus.instr_o); end
    bus.ready_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_compressed();
    test_straddle();
    test_full();
    test_flush_wait();
    test_flush_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
